cpu_controller: RTL and testbench
=================================

Name: cpu_controller

Overview:
Multicycle control FSM for the simple RISC datapath (register file, A/B/C registers, shifter, ALU, status register). It accepts a start strobe, decodes the opcode/op fields of the held instruction, and sequences datapath load, select and write enables over 1–5 cycles. It then raises `w` to signal readiness for the next instruction. It sits inside `cpu` between the instruction decoder and the datapath.

Parameters:
- ONEHOT_STATE, 0, 1 selects one-hot state encoding; 0 selects a binary 4-bit encoding. Externally visible behaviour is identical for both.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-low reset (the port keeps the codebase name; polarity and synchronicity are fixed)
- s  input  1  start strobe; sampled only in WAIT
- opcode  input  3  instruction[15:13]
- op  input  2  instruction[12:11]
- w  output  1  high only in WAIT (ready for the next instruction)
- nsel  output  3  register-file index select, one-hot: 100=Rn, 010=Rd, 001=Rm, 000=none
- vsel  output  2  write-back source: 0=C, 1=PC, 2=sximm8, 3=mdata
- write  output  1  register-file write enable
- loada  output  1  A register load
- loadb  output  1  B register load
- loadc  output  1  C register load
- loads  output  1  status (N,V,Z) load
- asel  output  1  1 forces the ALU A input to 0
- bsel  output  1  1 selects sximm5 for the ALU B input
- illegal  output  1  sticky flag: last decoded instruction was unsupported

Behaviour:
- Moore FSM. All control outputs are decoded combinationally from the registered state and latched fields. No output depends directly on s, opcode or op.
- States and outputs (unlisted outputs are 0):
  - WAIT: w=1
  - DECODE: all 0; captures opcode/op into internal regs
  - WR_IMM: nsel=100, vsel=2, write=1
  - GET_A: nsel=100, loada=1
  - GET_B: nsel=001, loadb=1
  - ALU: loadc=1; asel=1 for MOV-reg and MVN; loads=1 for CMP only; bsel=0
  - WR_REG: nsel=010, vsel=0, write=1
- Transitions:
  - WAIT stays in WAIT while s=0; s=1 at a rising edge goes to DECODE.
  - DECODE, by the latched {opcode,op}:
    - 110_10 (MOV imm) → WR_IMM → WAIT
    - 110_00 (MOV reg) and 101_11 (MVN) → GET_B → ALU → WR_REG → WAIT
    - 101_00 (ADD) and 101_10 (AND) → GET_A → GET_B → ALU → WR_REG → WAIT
    - 101_01 (CMP) → GET_A → GET_B → ALU → WAIT (no register write)
    - any other encoding → WAIT directly, and illegal is set to 1
- Edges from the s-accept edge until w=1: MOV imm 2, MOV reg 4, MVN 4, CMP 4, ADD 5, AND 5, illegal 1.
- opcode and op are sampled only on the edge that leaves DECODE. Changes after that point do not affect the running sequence.
- s is ignored outside WAIT. If s is held high, the next instruction starts on the first edge in WAIT, so w is high for exactly one cycle.
- illegal is cleared on the edge that enters DECODE and set on the edge leaving DECODE with an unsupported encoding.
- Reset (reset=0), including mid-sequence, acts immediately and asynchronously:
  - state=WAIT, so w=1 and every other output is 0
  - illegal=0 and the latched fields are cleared to 0
  - the first s is accepted on the first rising edge after reset returns high
- Only one of loada/loadb/loadc/write is ever asserted per cycle. write=1 never coincides with loads=1.

Decomposition:
- cpu_pkg holds:
  - state enum (WAIT, DECODE, WR_IMM, GET_A, GET_B, ALU, WR_REG)
  - opcode/op localparams
  - nsel one-hot constants (NSEL_RN, NSEL_RD, NSEL_RM)
  - vsel constants (VSEL_C, VSEL_PC, VSEL_IMM, VSEL_MDATA)
- Optional sub-module cpu_ctrl_decode: a purely combinational map from state plus latched fields to the output control vector. The next-state logic and registers stay in cpu_controller.

Test Plan:
1. Reset then s=1 for one cycle with opcode=110, op=10 → DECODE, then WR_IMM with nsel=100, vsel=2, write=1 for exactly one cycle; w=1 on the 2nd edge after accept; illegal=0.
2. opcode=101, op=00 (ADD) → loada(nsel=100), loadb(nsel=001), loadc(asel=0, loads=0), then write(nsel=010, vsel=0), one cycle each in that order; w=1 on the 5th edge.
3. opcode=101, op=01 (CMP) → loada, loadb, then loadc=1 with loads=1; write stays 0 throughout; w=1 on the 4th edge.
4. opcode=110, op=00, then opcode changed to 101 one cycle after accept → MOV-reg path unaffected (GET_B, ALU with asel=1, WR_REG); w=1 on the 4th edge.
5. opcode=111 → no load or write pulses; w=1 on the 1st edge after accept with illegal=1; the next valid MOV imm clears illegal at DECODE.
6. reset driven 0 mid-clock while in GET_B of an ADD → w=1 and all controls 0 immediately, before the next edge; after release, s=0 holds WAIT, and s=1 held for 3 MOV imm instructions gives back-to-back sequences with w high one cycle each.

Source files
------------

// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared states, instruction encodings and control vector for the cpu controller
package cpu_pkg;

    typedef enum logic [3:0] {
        ST_WAIT   = 4'd0,
        ST_DECODE = 4'd1,
        ST_WR_IMM = 4'd2,
        ST_GET_A  = 4'd3,
        ST_GET_B  = 4'd4,
        ST_ALU    = 4'd5,
        ST_WR_REG = 4'd6
    } state_e;

    localparam int NUM_STATES = 7;

    localparam logic [2:0] OPC_MOV = 3'b110;
    localparam logic [2:0] OPC_ALU = 3'b101;

    localparam logic [1:0] OP_MOV_IMM = 2'b10;
    localparam logic [1:0] OP_MOV_REG = 2'b00;
    localparam logic [1:0] OP_ADD     = 2'b00;
    localparam logic [1:0] OP_CMP     = 2'b01;
    localparam logic [1:0] OP_AND     = 2'b10;
    localparam logic [1:0] OP_MVN     = 2'b11;

    localparam logic [4:0] INSTR_MOV_IMM = {OPC_MOV, OP_MOV_IMM};
    localparam logic [4:0] INSTR_MOV_REG = {OPC_MOV, OP_MOV_REG};
    localparam logic [4:0] INSTR_ADD     = {OPC_ALU, OP_ADD};
    localparam logic [4:0] INSTR_CMP     = {OPC_ALU, OP_CMP};
    localparam logic [4:0] INSTR_AND     = {OPC_ALU, OP_AND};
    localparam logic [4:0] INSTR_MVN     = {OPC_ALU, OP_MVN};

    localparam logic [2:0] NSEL_NONE = 3'b000;
    localparam logic [2:0] NSEL_RN   = 3'b100;
    localparam logic [2:0] NSEL_RD   = 3'b010;
    localparam logic [2:0] NSEL_RM   = 3'b001;

    localparam logic [1:0] VSEL_C     = 2'd0;
    localparam logic [1:0] VSEL_PC    = 2'd1;
    localparam logic [1:0] VSEL_IMM   = 2'd2;
    localparam logic [1:0] VSEL_MDATA = 2'd3;

    typedef struct packed {
        logic       w;
        logic [2:0] nsel;
        logic [1:0] vsel;
        logic       write;
        logic       loada;
        logic       loadb;
        logic       loadc;
        logic       loads;
        logic       asel;
        logic       bsel;
    } ctrl_t;

    // State entered on the edge leaving DECODE; WAIT marks an unsupported encoding.
    function automatic state_e first_state(input logic [4:0] instr);
        case (instr)
            INSTR_MOV_IMM:              return ST_WR_IMM;
            INSTR_MOV_REG, INSTR_MVN:   return ST_GET_B;
            INSTR_ADD, INSTR_AND,
            INSTR_CMP:                  return ST_GET_A;
            default:                    return ST_WAIT;
        endcase
    endfunction

    function automatic logic is_supported(input logic [4:0] instr);
        return first_state(instr) != ST_WAIT;
    endfunction

endpackage

// File: rtl/cpu_ctrl_decode.sv
// rtl/cpu_ctrl_decode.sv - combinational map from controller state and latched fields to datapath controls
module cpu_ctrl_decode
    import cpu_pkg::*;
(
    input  state_e     state,
    input  logic [4:0] instr,
    output ctrl_t      ctrl
);

    always_comb begin
        ctrl = '0;
        case (state)
            ST_WAIT: begin
                ctrl.w = 1'b1;
            end
            ST_WR_IMM: begin
                ctrl.nsel  = NSEL_RN;
                ctrl.vsel  = VSEL_IMM;
                ctrl.write = 1'b1;
            end
            ST_GET_A: begin
                ctrl.nsel  = NSEL_RN;
                ctrl.loada = 1'b1;
            end
            ST_GET_B: begin
                ctrl.nsel  = NSEL_RM;
                ctrl.loadb = 1'b1;
            end
            ST_ALU: begin
                // Moves pass B through the ALU with A forced to zero.
                ctrl.loadc = 1'b1;
                ctrl.asel  = (instr == INSTR_MOV_REG) || (instr == INSTR_MVN);
                ctrl.loads = (instr == INSTR_CMP);
            end
            ST_WR_REG: begin
                ctrl.nsel  = NSEL_RD;
                ctrl.vsel  = VSEL_C;
                ctrl.write = 1'b1;
            end
            default: begin
                ctrl = '0;
            end
        endcase
    end

endmodule

// File: rtl/cpu_controller.sv
// rtl/cpu_controller.sv - multicycle control FSM sequencing the simple RISC datapath
module cpu_controller
    import cpu_pkg::*;
#(
    parameter bit ONEHOT_STATE = 1'b0
)
(
    input  logic       clk,
    input  logic       reset,
    input  logic       s,
    input  logic [2:0] opcode,
    input  logic [1:0] op,
    output logic       w,
    output logic [2:0] nsel,
    output logic [1:0] vsel,
    output logic       write,
    output logic       loada,
    output logic       loadb,
    output logic       loadc,
    output logic       loads,
    output logic       asel,
    output logic       bsel,
    output logic       illegal
);

    localparam int SW = ONEHOT_STATE ? NUM_STATES : 4;

    logic [SW-1:0] state_reg;
    state_e        state;
    logic [4:0]    instr_reg;
    logic          illegal_reg;
    ctrl_t         ctrl;

    function automatic logic [SW-1:0] encode_state(input state_e st);
        if (ONEHOT_STATE)
            return SW'(7'b1 << st);
        else
            return SW'(st);
    endfunction

    // Unreachable codes fall back to WAIT so a corrupted register recovers.
    function automatic state_e decode_state(input logic [SW-1:0] code);
        logic [6:0] wide;
        state_e     st;
        wide = 7'(code);
        st   = ST_WAIT;
        if (ONEHOT_STATE) begin
            for (int i = 0; i < NUM_STATES; i++) begin
                if (wide == 7'(1 << i))
                    st = state_e'(4'(i));
            end
        end else if (wide[3:0] <= 4'd6) begin
            st = state_e'(wide[3:0]);
        end
        return st;
    endfunction

    always_comb state = decode_state(state_reg);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg   <= encode_state(ST_WAIT);
            instr_reg   <= '0;
            illegal_reg <= 1'b0;
        end else begin
            case (state)
                ST_WAIT: begin
                    if (s) begin
                        state_reg   <= encode_state(ST_DECODE);
                        illegal_reg <= 1'b0;
                    end
                end
                ST_DECODE: begin
                    instr_reg   <= {opcode, op};
                    state_reg   <= encode_state(first_state({opcode, op}));
                    illegal_reg <= !is_supported({opcode, op});
                end
                ST_WR_IMM: state_reg <= encode_state(ST_WAIT);
                ST_GET_A:  state_reg <= encode_state(ST_GET_B);
                ST_GET_B:  state_reg <= encode_state(ST_ALU);
                ST_ALU: begin
                    // Compare only updates status; nothing is written back.
                    if (instr_reg == INSTR_CMP)
                        state_reg <= encode_state(ST_WAIT);
                    else
                        state_reg <= encode_state(ST_WR_REG);
                end
                ST_WR_REG: state_reg <= encode_state(ST_WAIT);
                default:   state_reg <= encode_state(ST_WAIT);
            endcase
        end
    end

    cpu_ctrl_decode u_decode (
        .state (state),
        .instr (instr_reg),
        .ctrl  (ctrl)
    );

    assign w       = ctrl.w;
    assign nsel    = ctrl.nsel;
    assign vsel    = ctrl.vsel;
    assign write   = ctrl.write;
    assign loada   = ctrl.loada;
    assign loadb   = ctrl.loadb;
    assign loadc   = ctrl.loadc;
    assign loads   = ctrl.loads;
    assign asel    = ctrl.asel;
    assign bsel    = ctrl.bsel;
    assign illegal = illegal_reg;

endmodule

// File: tb/tb_cpu_controller.sv
// tb/tb_cpu_controller.sv - randomized self-checking bench for cpu_controller, binary and one-hot builds
module tb_cpu_controller;

    logic       clk;
    logic       reset;
    logic       s;
    logic [2:0] opcode;
    logic [1:0] op;

    logic       w_b, write_b, loada_b, loadb_b, loadc_b, loads_b, asel_b, bsel_b, illegal_b;
    logic [2:0] nsel_b;
    logic [1:0] vsel_b;
    logic       w_o, write_o, loada_o, loadb_o, loadc_o, loads_o, asel_o, bsel_o, illegal_o;
    logic [2:0] nsel_o;
    logic [1:0] vsel_o;

    int total;
    int bad;
    bit model_ill;

    cpu_controller #(.ONEHOT_STATE(1'b0)) dut_bin (
        .clk(clk), .reset(reset), .s(s), .opcode(opcode), .op(op),
        .w(w_b), .nsel(nsel_b), .vsel(vsel_b), .write(write_b),
        .loada(loada_b), .loadb(loadb_b), .loadc(loadc_b), .loads(loads_b),
        .asel(asel_b), .bsel(bsel_b), .illegal(illegal_b)
    );

    cpu_controller #(.ONEHOT_STATE(1'b1)) dut_oh (
        .clk(clk), .reset(reset), .s(s), .opcode(opcode), .op(op),
        .w(w_o), .nsel(nsel_o), .vsel(vsel_o), .write(write_o),
        .loada(loada_o), .loadb(loadb_o), .loadc(loadc_o), .loads(loads_o),
        .asel(asel_o), .bsel(bsel_o), .illegal(illegal_o)
    );

    wire [13:0] obs_b = {w_b, nsel_b, vsel_b, write_b, loada_b, loadb_b, loadc_b, loads_b, asel_b, bsel_b, illegal_b};
    wire [13:0] obs_o = {w_o, nsel_o, vsel_o, write_o, loada_o, loadb_o, loadc_o, loads_o, asel_o, bsel_o, illegal_o};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [13:0] got, input logic [13:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%b exp=%b (w nsel vsel wr la lb lc ls as bs ill)", tag, got, exp);
        end
    endtask

    task automatic check_both(input string tag, input logic [13:0] exp);
        check({tag, "_bin"}, obs_b, exp);
        check({tag, "_oh"}, obs_o, exp);
    endtask

    function automatic logic [13:0] vec(input bit wv, input logic [2:0] ns, input logic [1:0] vs,
                                        input bit wr, input bit la, input bit lb, input bit lc,
                                        input bit ls, input bit as, input bit ill);
        return {wv, ns, vs, wr, la, lb, lc, ls, as, 1'b0, ill};
    endfunction

    // step codes: 1 write immediate, 2 load A, 3 load B, 4 ALU, 5 write result
    function automatic logic [13:0] step_vec(input int step, input bit mov_like, input bit is_cmp);
        case (step)
            1: return vec(0, 3'b100, 2'd2, 1, 0, 0, 0, 0, 0, 0);
            2: return vec(0, 3'b100, 2'd0, 0, 1, 0, 0, 0, 0, 0);
            3: return vec(0, 3'b001, 2'd0, 0, 0, 1, 0, 0, 0, 0);
            4: return vec(0, 3'b000, 2'd0, 0, 0, 0, 1, is_cmp, mov_like, 0);
            default: return vec(0, 3'b010, 2'd0, 1, 0, 0, 0, 0, 0, 0);
        endcase
    endfunction

    task automatic run_instr(input logic [2:0] opc, input logic [1:0] o, input int gap,
                             input bit hold, input bit scramble, input int abort_at);
        int  steps[$];
        bit  mov_like, is_cmp;
        logic [4:0] code;
        code = {opc, o};
        case (code)
            5'b110_10:            steps = {1};
            5'b110_00, 5'b101_11: steps = {3, 4, 5};
            5'b101_00, 5'b101_10: steps = {2, 3, 4, 5};
            5'b101_01:            steps = {2, 3, 4};
            default:              steps = {};
        endcase
        mov_like = (code == 5'b110_00) || (code == 5'b101_11);
        is_cmp   = (code == 5'b101_01);

        if (gap > 0) s = 1'b0;
        for (int g = 0; g < gap; g++) begin
            check_both("wait_idle", vec(1, 0, 0, 0, 0, 0, 0, 0, 0, model_ill));
            @(posedge clk); @(negedge clk);
        end
        check_both("wait_pre", vec(1, 0, 0, 0, 0, 0, 0, 0, 0, model_ill));
        s = 1'b1; opcode = opc; op = o;
        @(posedge clk); @(negedge clk);
        if (!hold) s = 1'b0;
        model_ill = 1'b0;
        check_both("decode", vec(0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        @(posedge clk); @(negedge clk);
        model_ill = (steps.size() == 0);
        if (scramble) begin
            opcode = 3'($urandom);
            op     = 2'($urandom);
        end
        for (int i = 0; i < steps.size(); i++) begin
            check_both($sformatf("step%0d_%b", i, code), step_vec(steps[i], mov_like, is_cmp));
            if (i == abort_at) begin
                #2 reset = 1'b0;
                #1;
                model_ill = 1'b0;
                check_both("reset_async", vec(1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
                @(negedge clk);
                check_both("reset_held", vec(1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
                reset = 1'b1;
                s = 1'b0;
                return;
            end
            @(posedge clk); @(negedge clk);
        end
    endtask

    localparam logic [4:0] valid_tab [6] = '{5'b110_10, 5'b110_00, 5'b101_11, 5'b101_00, 5'b101_10, 5'b101_01};

    initial begin
        total = 0; bad = 0; model_ill = 1'b0;
        reset = 1'b0; s = 1'b0; opcode = '0; op = '0;
        @(negedge clk);
        check_both("reset", vec(1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        reset = 1'b1;
        @(negedge clk);

        run_instr(3'b110, 2'b10, 1, 0, 0, -1);   // MOV imm
        run_instr(3'b101, 2'b00, 1, 0, 1, -1);   // ADD
        run_instr(3'b101, 2'b01, 0, 0, 1, -1);   // CMP
        opcode = 3'b110; op = 2'b00;
        run_instr(3'b110, 2'b00, 2, 0, 0, -1);   // MOV reg, then opcode changed below
        run_instr(3'b110, 2'b00, 0, 0, 1, -1);
        run_instr(3'b101, 2'b11, 1, 0, 1, -1);   // MVN
        run_instr(3'b101, 2'b10, 1, 0, 1, -1);   // AND
        run_instr(3'b111, 2'b00, 1, 0, 0, -1);   // illegal
        run_instr(3'b110, 2'b10, 2, 0, 0, -1);   // clears illegal
        run_instr(3'b000, 2'b11, 0, 0, 1, -1);
        run_instr(3'b101, 2'b00, 1, 0, 0, 1);    // ADD aborted in GET_B
        run_instr(3'b110, 2'b10, 3, 1, 0, -1);   // three back-to-back MOV imm
        run_instr(3'b110, 2'b10, 0, 1, 0, -1);
        run_instr(3'b110, 2'b10, 0, 0, 0, -1);

        for (int n = 0; n < 200; n++) begin
            logic [4:0] code;
            int gap;
            if ($urandom_range(0, 3) == 0) code = 5'($urandom);
            else                           code = valid_tab[$urandom_range(0, 5)];
            gap = $urandom_range(0, 2);
            run_instr(code[4:2], code[1:0], gap, 1'($urandom), 1'($urandom),
                      ($urandom_range(0, 19) == 0) ? 0 : -1);
        end

        s = 1'b0;
        @(negedge clk);
        check_both("final_wait", vec(1, 0, 0, 0, 0, 0, 0, 0, 0, model_ill));
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
